// File: rtl/mul_unit.sv
// Iterative shift-add multiplier for MUL/MLA: one multiplier bit per cycle,
// with a single-cycle register/flag write-back request on completion.
module mul_unit #(
   parameter bit EARLY_TERM = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        accumulate,
   input  logic        set_flags,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic [31:0] op_acc,
   input  logic [3:0]  rd_sel,
   input  logic [3:0]  flags_in,
   output logic        busy,
   output logic        done,
   output logic        wr_en,
   output logic [3:0]  wr_sel,
   output logic [31:0] result,
   output logic        flags_wr,
   output logic [3:0]  flags_out
);

   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

   state_t      state_q, state_d;
   logic [31:0] mcand_q, mcand_d;
   logic [31:0] mplier_q, mplier_d;
   logic [31:0] acc_q, acc_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [3:0]  rd_q, rd_d;
   logic        sf_q, sf_d;
   logic [3:0]  fl_q, fl_d;
   logic [31:0] result_q, result_d;
   logic [3:0]  wr_sel_q, wr_sel_d;
   logic [3:0]  flags_out_q, flags_out_d;

   logic        last_iter;
   logic        capture;
   logic [31:0] acc_sum;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         mcand_q     <= '0;
         mplier_q    <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         rd_q        <= '0;
         sf_q        <= 1'b0;
         fl_q        <= '0;
         result_q    <= '0;
         wr_sel_q    <= '0;
         flags_out_q <= '0;
      end else begin
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         rd_q        <= rd_d;
         sf_q        <= sf_d;
         fl_q        <= fl_d;
         result_q    <= result_d;
         wr_sel_q    <= wr_sel_d;
         flags_out_q <= flags_out_d;
      end
   end

   // The current iteration is the last one if it is the 32nd, or (early
   // termination) if no set bits remain above the bit consumed now.
   assign last_iter = (cnt_q == 5'd31) || (EARLY_TERM && (mplier_q[31:1] == 31'd0));
   assign capture   = start && (state_q != MUL);
   assign acc_sum   = acc_q + (mplier_q[0] ? mcand_q : 32'd0);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = start ? MUL : IDLE;
         MUL:     state_d = last_iter ? DONE : MUL;
         DONE:    state_d = start ? MUL : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      rd_d        = rd_q;
      sf_d        = sf_q;
      fl_d        = fl_q;
      result_d    = result_q;
      wr_sel_d    = wr_sel_q;
      flags_out_d = flags_out_q;
      if (capture) begin
         mcand_d  = op_a;
         mplier_d = op_b;
         acc_d    = accumulate ? op_acc : 32'd0;
         cnt_d    = 5'd0;
         rd_d     = rd_sel;
         sf_d     = set_flags;
         fl_d     = flags_in;
      end else if (state_q == MUL) begin
         acc_d    = acc_sum;
         mcand_d  = {mcand_q[30:0], 1'b0};
         mplier_d = {1'b0, mplier_q[31:1]};
         cnt_d    = cnt_q + 5'd1;
         // Write-back values are registered on the way into DONE so they
         // persist until the next completion.
         if (last_iter) begin
            result_d    = acc_sum;
            wr_sel_d    = rd_q;
            flags_out_d = sf_q ? {acc_sum[31], (acc_sum == 32'd0), fl_q[1:0]} : fl_q;
         end
      end
   end

   always_comb begin
      busy      = (state_q == MUL);
      done      = (state_q == DONE);
      wr_en     = (state_q == DONE);
      flags_wr  = (state_q == DONE) && sf_q;
      result    = result_q;
      wr_sel    = wr_sel_q;
      flags_out = flags_out_q;
   end

endmodule

// File: doc/mul_unit.md
# mul_unit

Iterative shift-add multiplier for MUL/MLA, sitting directly downstream of the register file read ports in the execute stage. Takes two operands (plus an optional accumulator) from the `p0`/`p1` read ports, computes the low 32 bits of Rm*Rs(+Rn) over several cycles, and returns a single-cycle write-back request (`in_reg`/`sel_in`-style data and selector) plus updated NZCV flags for the register file. The pipeline stalls on `busy`.

## Interface
- `EARLY_TERM`, default 1: when 1, the unit stops iterating once the remaining multiplier bits are all zero; when 0, it always performs 32 iterations.

- `clock`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  request a multiply; sampled on a rising edge
- `accumulate`  in  1  1 = MLA (add `op_acc`), 0 = MUL
- `set_flags`  in  1  S bit; update N and Z
- `op_a`  in  32  multiplicand Rm (from `p0`)
- `op_b`  in  32  multiplier Rs (from `p1`)
- `op_acc`  in  32  accumulator Rn
- `rd_sel`  in  4  destination register index
- `flags_in`  in  4  current flags {N,Z,C,V}, bit 3 = N
- `busy`  out  1  iteration in progress
- `done`  out  1  one-cycle completion pulse
- `wr_en`  out  1  register write strobe (equal to `done`)
- `wr_sel`  out  4  destination index for the write
- `result`  out  32  product / accumulated sum
- `flags_wr`  out  1  flag write strobe
- `flags_out`  out  4  new flags {N,Z,C,V}

## Operation
- States: IDLE, MUL, DONE. Encoding is free.
- **Capture** (start sampled high in IDLE or DONE):
  - latch `mcand=op_a`, `mplier=op_b`, `acc = accumulate ? op_acc : 0`;
  - latch `rd_sel`, `set_flags`, `flags_in`;
  - go to MUL.
- **MUL**, once per cycle:
  - if `mplier[0]`, `acc += mcand` (mod 2^32);
  - `mcand <<= 1`; `mplier >>= 1`; iteration counter +1.
- **Leaving MUL**: go to DONE after the 32nd iteration. If `EARLY_TERM=1`, also go to DONE when the shifted multiplier becomes 0. The minimum is 1 iteration, even when `op_b=0`.
- **DONE** (exactly one cycle):
  - `done=wr_en=1`, `result=acc`, `wr_sel` = latched rd;
  - `flags_wr` = latched set_flags.
  - If set_flags, `flags_out = {acc[31], acc==0, C_latched, V_latched}`; otherwise `flags_out` = latched flags.
  - Next state is IDLE, or MUL if `start` is high (back-to-back accepted).
- `start` in MUL is ignored. Operand inputs are don't-care except at the capture edge.
- Arithmetic is unsigned and sign-agnostic; only the low 32 bits are kept. Accumulator overflow wraps silently.
- `rd_sel=15` (PC) receives no special treatment; the register file owns PC handling.
- **Reset** (any state, including mid-MUL): next state IDLE. No write or flag strobe is issued for the aborted operation.

## Timing
- Reset values: `busy=0`, `done=0`, `wr_en=0`, `flags_wr=0`, `wr_sel=0`, `result=0`, `flags_out=0`. State is IDLE and internal registers are 0.
- All outputs are registered or decoded from state only; there are no combinational input-to-output paths.
- `busy=1` exactly while in MUL: from the cycle after the capture edge until the last iteration edge.
- Latency: with N iterations (`EARLY_TERM=1`: N = max(1, index of highest set bit of `op_b` + 1); `EARLY_TERM=0`: N = 32), `done` is high in cycle N+1 after the capture edge.
- `result` and `flags_out` hold their DONE values until the next DONE or reset. `wr_sel` holds likewise.
- `wr_en`/`flags_wr` never assert outside DONE.
- Back-to-back: a start sampled in DONE gives `busy=1` in the following cycle with no IDLE gap.

## Test plan
- `EARLY_TERM=1`, MUL `op_a=0x12345678`, `op_b=3`, `rd_sel=2` -> 2 busy cycles; `done`/`wr_en` pulse 3 cycles after start; `result=0x369D0368`, `wr_sel=2`, `flags_wr=0`.
- MLA `op_a=op_b=0xFFFFFFFF`, `op_acc=5`, `set_flags=1`, `flags_in=4'b0011` -> 32 busy cycles; `result=0x00000006`, `flags_out=4'b0011`, `flags_wr=1`.
- MUL `op_a=0x1234`, `op_b=0`, `set_flags=1`, `flags_in=4'b1000` -> 1 iteration; `result=0`, `flags_out=4'b0100`.
- MUL `op_a=0xFFFFFFFE`, `op_b=3`, `set_flags=1`, `flags_in=0` -> `result=0xFFFFFFFA`, `flags_out=4'b1000`. Repeat with `EARLY_TERM=0` -> identical result, `done` at cycle 33.
- Start MUL `0x10*0x80000000`; pulse `start` again at busy cycle 5 (ignored); assert `reset` at busy cycle 10 -> `busy` drops the next cycle, no `wr_en`, all outputs 0.
- Two back-to-back ops (`7*6`, then `start` held during DONE for `9*9`) -> `result=0x2A` pulse, then `busy` the next cycle, then `result=0x51` pulse.
